instr_prefetch_queue: RTL and testbench



---
 rtl/vslc_pkg.sv | 18 +
 rtl/sync_fifo_showahead.sv | 55 +++++
 rtl/instr_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// Shared constants for the EEPROM-fed stack machine: header layout,
// prefetch-queue state encodings and the reader's SPI opcode.
package vslc_pkg;

    localparam int HEADER_BYTES = 4;
    localparam int PROG_W       = 10;

    localparam logic [2:0] ST_HDR0  = 3'd0;
    localparam logic [2:0] ST_HDR1  = 3'd1;
    localparam logic [2:0] ST_HDR2  = 3'd2;
    localparam logic [2:0] ST_HDR3  = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_HALT  = 3'd6;

    localparam logic [7:0] EEPROM_READ_INSTR = 8'h03;

endpackage

// File: rtl/sync_fifo_showahead.sv
// Show-ahead synchronous FIFO: dout always presents the head entry.
// A push while full is only taken when a pop frees a slot in the same
// cycle; a pop while empty is ignored, so there is no write-through bypass.
module sync_fifo_showahead #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, wptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q];
    assign level   = cnt_q;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between the SPI EEPROM reader and the
// executor. Parses the 4-byte start/end header, queues in-window bytes,
// and on end-of-program waits for the queue to drain before asking the
// reader to restart at start_addr.
module instr_prefetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PROG_W = vslc_pkg::PROG_W,
    parameter int ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    input  logic [ADDR_W-1:0]      byte_addr,
    output logic                   instr_valid,
    output logic [7:0]             instr_data,
    input  logic                   instr_ready,
    output logic                   restart_o,
    output logic                   scan_done,
    output logic [PROG_W-1:0]      start_addr,
    output logic [PROG_W-1:0]      end_addr,
    output logic                   header_err,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    import vslc_pkg::*;

    localparam int HI_W = PROG_W - 8;

    logic [2:0]        state_q, state_d;
    logic [PROG_W-1:0] start_q, start_d;
    logic [PROG_W-1:0] end_q, end_d;
    logic              herr_q, herr_d;
    logic              ovf_q, ovf_d;

    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [ADDR_W-1:0] start_ext, end_ext;
    logic [PROG_W-1:0] end_new;
    logic              free_run, in_win, end_hit;

    assign start_ext = ADDR_W'(start_q);
    assign end_ext   = ADDR_W'(end_q);
    assign free_run  = (end_q == '0);
    // end value as it will be once the HDR3 byte is captured
    assign end_new   = {end_q[PROG_W-1:8], byte_data};

    assign in_win  = byte_valid
                  && (byte_addr >= ADDR_W'(HEADER_BYTES))
                  && (byte_addr >= start_ext)
                  && (free_run || (byte_addr <= end_ext));
    assign end_hit = in_win && !free_run && (byte_addr == end_ext);

    assign fifo_push = (state_q == ST_RUN) && in_win;
    assign fifo_pop  = instr_ready && !fifo_empty;

    // Restart fires in the first DRAIN cycle that sees an empty queue;
    // the FSM leaves DRAIN on the same edge, so this is a one-cycle pulse.
    assign restart_o = (state_q == ST_DRAIN) && fifo_empty;
    assign scan_done = restart_o;

    assign instr_valid = !fifo_empty;
    assign start_addr  = start_q;
    assign end_addr    = end_q;
    assign header_err  = herr_q;
    assign overflow    = ovf_q;

    // Header parse, window tracking and end-of-program sequencing.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        end_d   = end_q;
        herr_d  = herr_q;
        ovf_d   = ovf_q | (fifo_push & fifo_full & ~fifo_pop);
        case (state_q)
            ST_HDR0: if (byte_valid && byte_addr == ADDR_W'(0)) begin
                start_d[PROG_W-1:8] = byte_data[HI_W-1:0];
                state_d             = ST_HDR1;
            end
            ST_HDR1: if (byte_valid && byte_addr == ADDR_W'(1)) begin
                start_d[7:0] = byte_data;
                state_d      = ST_HDR2;
            end
            ST_HDR2: if (byte_valid && byte_addr == ADDR_W'(2)) begin
                end_d[PROG_W-1:8] = byte_data[HI_W-1:0];
                state_d           = ST_HDR3;
            end
            ST_HDR3: if (byte_valid && byte_addr == ADDR_W'(3)) begin
                end_d[7:0] = byte_data;
                if (end_new != '0 && end_new < start_q) begin
                    herr_d  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:   if (end_hit)    state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_RUN;
            default:  state_d = state_q;
        endcase
    end

    // Control registers; reset restarts the header parse and clears flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HDR0;
            start_q <= '0;
            end_q   <= '0;
            herr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            herr_q  <= herr_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo_showahead #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (byte_data),
        .dout  (instr_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue; popped bytes are checked
// against a queue of expected bytes filled as stimulus is issued.
module tb_instr_prefetch_queue;

    localparam int DEPTH  = 4;
    localparam int PROG_W = 10;
    localparam int ADDR_W = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [ADDR_W-1:0] byte_addr;
    logic              instr_valid;
    logic [7:0]        instr_data;
    logic              instr_ready;
    logic              restart_o;
    logic              scan_done;
    logic [PROG_W-1:0] start_addr;
    logic [PROG_W-1:0] end_addr;
    logic              header_err;
    logic              overflow;
    logic [LW-1:0]     level;

    int         total = 0;
    int         bad   = 0;
    int         restart_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    instr_prefetch_queue #(.DEPTH(DEPTH), .PROG_W(PROG_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_addr(byte_addr), .instr_valid(instr_valid), .instr_data(instr_data),
        .instr_ready(instr_ready), .restart_o(restart_o), .scan_done(scan_done),
        .start_addr(start_addr), .end_addr(end_addr), .header_err(header_err),
        .overflow(overflow), .level(level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // monitor: every accepted pop is compared with the scoreboard head
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %0h want none", instr_data);
            end else begin
                chk("pop_data", instr_data, exp_q.pop_front());
            end
        end
        if (restart_o || scan_done) begin
            chk("scan_done_eq_restart", scan_done, restart_o);
            if (restart_o) restart_cnt++;
        end
    end

    task automatic send(input int addr, input logic [7:0] data, input bit push_exp);
        byte_addr  = ADDR_W'(addr);
        byte_data  = data;
        byte_valid = 1'b1;
        if (push_exp) exp_q.push_back(data);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        exp_q.delete();
        byte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic header(input int s, input int e);
        logic [15:0] sv, ev;
        sv = 16'(s);
        ev = 16'(e);
        send(0, sv[15:8], 0);
        send(1, sv[7:0],  0);
        send(2, ev[15:8], 0);
        send(3, ev[7:0],  0);
    endtask

    task automatic wait_restart(input int target);
        for (int i = 0; i < 30; i++) begin
            if (restart_cnt >= target) break;
            @(posedge clk); #1;
        end
        chk("restart_seen", restart_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_data = '0; byte_addr = '0; instr_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_restart", restart_o, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_start", start_addr, 0);
        chk("rst_end", end_addr, 0);
        chk("rst_herr", header_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", level, 0);
        chk("rst_state", dut.state_q, vslc_pkg::ST_HDR0);
        @(posedge clk); #1;
        rst = 1'b0;

        // header parse; a stray address in HDR0 must be ignored
        send(5, 8'hAA, 0);
        chk("hdr0_ignore", dut.state_q, vslc_pkg::ST_HDR0);
        header(4, 7);
        chk("hdr_start", start_addr, 4);
        chk("hdr_end", end_addr, 7);
        chk("hdr_err", header_err, 0);
        chk("hdr_state_run", dut.state_q, vslc_pkg::ST_RUN);

        // windowed streaming, end-of-program drain and restart
        instr_ready = 1'b1;
        send(4, 8'h81, 1);
        @(negedge clk);
        chk("lat_valid", instr_valid, 1);
        chk("lat_data", instr_data, 8'h81);
        @(posedge clk); #1;
        send(5, 8'h30, 1);
        send(6, 8'h02, 1);
        send(7, 8'hF0, 1);
        send(8, 8'h11, 0);
        send(9, 8'h22, 0);
        wait_restart(1);
        idle(3);
        chk("restart_once", restart_cnt, 1);
        chk("stream_drained", exp_q.size(), 0);
        chk("after_restart_run", dut.state_q, vslc_pkg::ST_RUN);

        // overflow with a free-run header
        pulse_reset();
        header(4, 0);
        instr_ready = 1'b0;
        send(4, 8'h01, 1);
        send(5, 8'h02, 1);
        send(6, 8'h03, 1);
        send(7, 8'h04, 1);
        send(8, 8'h05, 0);
        @(negedge clk);
        chk("ovf_level", level, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head_valid", instr_valid, 1);
        chk("ovf_head", instr_data, 8'h01);

        // push and pop together while full
        @(posedge clk); #1;
        instr_ready = 1'b1;
        send(9, 8'h06, 1);
        instr_ready = 1'b0;
        @(negedge clk);
        chk("full_pp_level", level, 4);
        chk("full_pp_ovf_sticky", overflow, 1);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        idle(6);
        chk("full_pp_drained_level", level, 0);
        chk("full_pp_drained_sb", exp_q.size(), 0);

        // free-run: long stream never triggers a restart
        for (int i = 0; i < 100; i++) send(10 + i, 8'(i * 7 + 3), 1);
        idle(4);
        chk("free_run_no_restart", restart_cnt, 1);
        chk("free_run_level", level, 0);
        chk("free_run_sb", exp_q.size(), 0);
        chk("free_run_state", dut.state_q, vslc_pkg::ST_RUN);

        // inverted header halts
        pulse_reset();
        header(10, 5);
        chk("err_flag", header_err, 1);
        chk("err_state", dut.state_q, vslc_pkg::ST_HALT);
        chk("err_start", start_addr, 10);
        chk("err_end", end_addr, 5);
        send(10, 8'h55, 0);
        send(11, 8'h66, 0);
        idle(2);
        chk("halt_level", level, 0);
        chk("halt_valid", instr_valid, 0);
        chk("halt_no_restart", restart_cnt, 1);

        // reset while in DRAIN with a full queue
        pulse_reset();
        chk("rst_clears_herr", header_err, 0);
        header(4, 8);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4 + i, 8'(8'hA0 + i), 0);
        chk("pre_rst_drain", dut.state_q, vslc_pkg::ST_DRAIN);
        chk("pre_rst_ovf", overflow, 1);
        chk("pre_rst_level", level, 4);
        pulse_reset();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_state", dut.state_q, vslc_pkg::ST_HDR0);
        chk("mid_rst_start", start_addr, 0);
        idle(10);
        chk("mid_rst_no_restart", restart_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
